// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer bank: protocol FSM states
// and the word-index width derived from the bank depth.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic int word_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// One DEPTH x DATA_WIDTH register bank: synchronous write and clear,
// combinational read on the shared word address.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    localparam int AW        = word_bits(DEPTH)
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    assign rdata = mem_reg[addr];

endmodule

// File: rtl/apb_slave_bank.sv
// APB completer with NUM_SLAVES independent register banks, a SETUP/ACCESS
// protocol FSM, configurable wait states and decode-error signalling.
module apb_slave_bank
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES  = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [NUM_SLAVES-1:0] Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [ADDR_WIDTH-1:0] Paddr,
    input  logic [DATA_WIDTH-1:0] Pwdata,
    output logic [DATA_WIDTH-1:0] Prdata,
    output logic                  Pready,
    output logic                  Pslverr
);

    localparam int WORD_BITS = word_bits(DEPTH);

    apb_state_e            state_reg;
    logic [3:0]            cnt_reg;
    logic [NUM_SLAVES-1:0] sel_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  write_reg;

    logic                  new_setup;
    logic                  setup_match;
    logic                  ready;
    logic                  err;
    int unsigned           sel_count;
    logic [WORD_BITS-1:0]  word;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_SLAVES];

    assign new_setup   = (|Pselx) && !Penable;
    assign setup_match = Penable && (Pselx == sel_reg) && (Paddr == addr_reg)
                         && (Pwrite == write_reg);
    assign ready       = (state_reg == ACCESS) && (cnt_reg == 4'd0);

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            sel_reg   <= '0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (new_setup) begin
                        state_reg <= SETUP;
                        sel_reg   <= Pselx;
                        addr_reg  <= Paddr;
                        write_reg <= Pwrite;
                    end
                end
                SETUP: begin
                    if (setup_match) begin
                        state_reg <= ACCESS;
                        cnt_reg   <= 4'(WAIT_STATES);
                    end else if (new_setup) begin
                        state_reg <= SETUP;
                        sel_reg   <= Pselx;
                        addr_reg  <= Paddr;
                        write_reg <= Pwrite;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS: begin
                    if (ready) begin
                        if (new_setup) begin
                            state_reg <= SETUP;
                            sel_reg   <= Pselx;
                            addr_reg  <= Paddr;
                            write_reg <= Pwrite;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (!Penable || (Pselx != sel_reg)) begin
                        // Requester abandoned the transfer before completion.
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One-hot select collapses the bank index into an OR of the selected bank.
    always_comb begin
        sel_count = 0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_reg[i]) begin
                sel_count = sel_count + 1;
                sel_rdata = sel_rdata | bank_rdata[i];
            end
        end
    end

    assign word = addr_reg[2 +: WORD_BITS];
    assign err  = (sel_count > 1) || (addr_reg[1:0] != 2'b00)
                  || (|addr_reg[ADDR_WIDTH-1:2+WORD_BITS]);

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_bank
            apb_reg_bank #(
                .DEPTH      (DEPTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_bank (
                .Hclk   (Hclk),
                .Hreset (Hreset),
                .we     (ready && write_reg && !err && sel_reg[gi]),
                .addr   (word),
                .wdata  (Pwdata),
                .rdata  (bank_rdata[gi])
            );
        end
    endgenerate

    assign Pready  = ready;
    assign Pslverr = ready && err;
    assign Prdata  = (ready && !write_reg && !err) ? sel_rdata : '0;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench: three instances (0, 3 and 2 wait states) on a shared bus,
// each with its own select lines, driven from a vector table plus corner cases.
module tb_apb_slave_bank;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [2:0]  psel_v   [3];
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] prdata_v [3];
    logic        pready_v [3];
    logic        pslverr_v[3];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Hclk = ~Hclk;

    apb_slave_bank #(.WAIT_STATES(0)) u_dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(psel_v[0]), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata_v[0]), .Pready(pready_v[0]), .Pslverr(pslverr_v[0]));

    apb_slave_bank #(.WAIT_STATES(3)) u_dut3 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(psel_v[1]), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata_v[1]), .Pready(pready_v[1]), .Pslverr(pslverr_v[1]));

    apb_slave_bank #(.WAIT_STATES(2)) u_dut2 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(psel_v[2]), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata_v[2]), .Pready(pready_v[2]), .Pslverr(pslverr_v[2]));

    typedef struct {
        int          dut;        // 0: 0 waits, 1: 3 waits, 2: 2 waits
        logic [2:0]  sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_k;      // ACCESS cycle in which Pready rises
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        for (int d = 0; d < 3; d++) psel_v[d] = 3'b000;
        Penable = 1'b0;
    endtask

    // Called just after a posedge; returns just after the completing posedge.
    task automatic apb_xfer(input int dut, input logic [2:0] sel, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err,
                            output int k, output logic early_bad);
        bus_idle();
        psel_v[dut] = sel;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = wdata;
        k         = 99;
        early_bad = 1'b0;
        rdata     = '0;
        err       = 1'b0;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Hclk);
            @(negedge Hclk);
            if (pready_v[dut]) begin
                k     = c;
                rdata = prdata_v[dut];
                err   = pslverr_v[dut];
                break;
            end
            if (prdata_v[dut] !== 32'h0 || pslverr_v[dut] !== 1'b0) early_bad = 1'b1;
        end
        @(posedge Hclk); #1;
        bus_idle();
    endtask

    vec_t        vecs[$];
    logic [31:0] rd;
    logic        er;
    int          kk;
    logic        eb;
    logic        seen;

    initial begin
        vecs.push_back('{0, 3'b001, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 1});
        vecs.push_back('{0, 3'b001, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 1});
        vecs.push_back('{0, 3'b001, 1'b1, 32'h0C, 32'h11,       32'h0,        1'b0, 1});
        vecs.push_back('{0, 3'b100, 1'b1, 32'h0C, 32'h22,       32'h0,        1'b0, 1});
        vecs.push_back('{0, 3'b001, 1'b0, 32'h0C, 32'h0,        32'h11,       1'b0, 1});
        vecs.push_back('{0, 3'b100, 1'b0, 32'h0C, 32'h0,        32'h22,       1'b0, 1});
        vecs.push_back('{0, 3'b010, 1'b0, 32'h0C, 32'h0,        32'h0,        1'b0, 1});
        vecs.push_back('{0, 3'b001, 1'b1, 32'h02, 32'hAAAA0001, 32'h0,        1'b1, 1});
        vecs.push_back('{0, 3'b001, 1'b1, 32'h40, 32'hAAAA0002, 32'h0,        1'b1, 1});
        vecs.push_back('{0, 3'b011, 1'b1, 32'h08, 32'h55555555, 32'h0,        1'b1, 1});
        vecs.push_back('{0, 3'b001, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 1});
        vecs.push_back('{0, 3'b001, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0, 1});
        vecs.push_back('{0, 3'b010, 1'b0, 32'h08, 32'h0,        32'h0,        1'b0, 1});
        vecs.push_back('{0, 3'b001, 1'b0, 32'h44, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1, 3'b010, 1'b0, 32'h04, 32'h0,        32'h0,        1'b0, 4});
        vecs.push_back('{1, 3'b010, 1'b1, 32'h04, 32'hCAFEF00D, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 3'b010, 1'b0, 32'h04, 32'h0,        32'hCAFEF00D, 1'b0, 4});

        bus_idle();
        Pwrite = 1'b0;
        Paddr  = '0;
        Pwdata = '0;
        Hreset = 1'b1;
        @(posedge Hclk); @(posedge Hclk); #1;
        Hreset = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge Hclk);
            check($sformatf("reset_idle_c%0d", c),
                  {prdata_v[0][29:0], pready_v[0], pslverr_v[0]}, 32'h0);
        end
        @(posedge Hclk); #1;

        foreach (vecs[i]) begin
            apb_xfer(vecs[i].dut, vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     rd, er, kk, eb);
            $display("[TB] vec %0d dut=%0d sel=%b wr=%0b addr=0x%0h rdata=0x%08h err=%0b k=%0d",
                     i, vecs[i].dut, vecs[i].sel, vecs[i].wr, vecs[i].addr, rd, er, kk);
            check($sformatf("v%0d_ready_cycle", i), kk, vecs[i].exp_k);
            check($sformatf("v%0d_pslverr", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_early_zero", i), {31'h0, eb}, 32'h0);
        end

        // Penable already high in IDLE must not start a transfer.
        psel_v[0] = 3'b001; Paddr = 32'h08; Pwrite = 1'b0; Penable = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Hclk);
            if (pready_v[0]) seen = 1'b1;
        end
        check("idle_penable_ignored", {31'h0, seen}, 32'h0);
        $display("[TB] idle penable: pready_seen=%0b", seen);
        @(posedge Hclk); #1;
        bus_idle();
        @(posedge Hclk); #1;

        // Select dropped mid-ACCESS on the 2-wait-state instance.
        psel_v[2] = 3'b010; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h77;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk);
        seen = 1'b0;
        @(negedge Hclk);
        if (pready_v[2]) seen = 1'b1;
        @(posedge Hclk); #1;
        bus_idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge Hclk);
            if (pready_v[2]) seen = 1'b1;
        end
        check("abort_no_ready", {31'h0, seen}, 32'h0);
        $display("[TB] abort: pready_seen=%0b", seen);
        @(posedge Hclk); #1;
        apb_xfer(2, 3'b010, 1'b0, 32'h10, 32'h0, rd, er, kk, eb);
        $display("[TB] abort readback rdata=0x%08h k=%0d", rd, kk);
        check("abort_readback", rd, 32'h0);
        check("abort_readback_k", kk, 3);

        // Reset during ACCESS of a write on the 3-wait-state instance.
        psel_v[1] = 3'b001; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'h99;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b1;
        seen = 1'b0;
        @(negedge Hclk);
        if (pready_v[1]) seen = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        bus_idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge Hclk);
            if (pready_v[1] || pslverr_v[1] || prdata_v[1] != 32'h0) seen = 1'b1;
        end
        check("reset_abort_quiet", {31'h0, seen}, 32'h0);
        $display("[TB] reset mid-access: activity_seen=%0b", seen);
        @(posedge Hclk); #1;
        apb_xfer(1, 3'b001, 1'b0, 32'h14, 32'h0, rd, er, kk, eb);
        $display("[TB] reset readback rdata=0x%08h k=%0d", rd, kk);
        check("reset_readback", rd, 32'h0);
        check("reset_readback_k", kk, 4);
        apb_xfer(0, 3'b001, 1'b0, 32'h08, 32'h0, rd, er, kk, eb);
        $display("[TB] reset cleared bank rdata=0x%08h", rd);
        check("reset_clears_bank", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_slave_bank.md
Name: apb_slave_bank

Overview:
- Parametrised APB completer model that replaces the fixed, random-data APB endpoint in the AHB-to-APB bridge environment.
- Provides NUM_SLAVES independent word-addressed register banks, each selected by one bit of Pselx.
- Adds real write storage with read-back, a SETUP/ACCESS protocol FSM, configurable wait states (Pready) and error signalling (Pslverr).
- Sits on the APB side of the bridge and acts as the DUT's target for both directed and random OOP-testbench traffic.

Parameters:
- NUM_SLAVES, 3: number of select bits/banks; Pselx width.
- ADDR_WIDTH, 32: Paddr width.
- DATA_WIDTH, 32: Pwdata/Prdata width; must be 32.
- DEPTH, 16: words per bank; power of two, at least 2.
- WAIT_STATES, 0: extra ACCESS cycles before Pready; range 0..15.

Ports:
- Hclk  in  1  APB/system clock; all state updates on posedge.
- Hreset  in  1  synchronous reset, active-high.
- Pselx  in  NUM_SLAVES  one-hot bank select.
- Penable  in  1  APB enable (ACCESS phase).
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  ADDR_WIDTH  byte address.
- Pwdata  in  DATA_WIDTH  write data.
- Prdata  out  DATA_WIDTH  read data; valid only while Pready=1 on a read.
- Pready  out  1  transfer completion.
- Pslverr  out  1  error response; valid only while Pready=1.

Behaviour:
- Reset (Hreset=1 at a posedge):
  - FSM goes to IDLE; wait counter cleared.
  - All bank words cleared to 0.
  - Outputs in the following cycle: Prdata=0, Pready=0, Pslverr=0.
  - Reset mid-transfer aborts it with no write.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when |Pselx && !Penable.
  - SETUP -> ACCESS when Penable=1 and Pselx, Paddr, Pwrite are unchanged from the SETUP cycle. These values are latched at SETUP entry. Otherwise SETUP -> IDLE, or SETUP -> SETUP if a new select is present with Penable=0.
  - ACCESS: the wait counter loads WAIT_STATES on entry and decrements each cycle.
  - Pready = (state==ACCESS) && (cnt==0), decoded combinationally from registered state.
  - ACCESS -> IDLE on the edge where Pready=1, or ACCESS -> SETUP if a back-to-back select with Penable=0 is present.
  - ACCESS -> IDLE immediately, with no write, if Pselx goes to 0 or changes, or Penable drops before Pready.
  - Penable=1 seen in IDLE is ignored: no Pready, FSM stays in IDLE.
- Latency: with WAIT_STATES=0, Pready is high in the first ACCESS cycle (two cycles per transfer). Each wait state adds one cycle.
- Decode (uses latched values):
  - bank = index of the set Pselx bit.
  - word = Paddr[2 +: log2(DEPTH)].
  - Error if any of: more than one Pselx bit set; Paddr[1:0] != 0; any Paddr bit above the word field is set.
- Write: committed to bank[word] at the posedge where Pready=1, Pwrite=1 and no error.
- Read: Prdata = bank[word] combinationally while Pready=1 && !Pwrite && no error.
- Prdata = 0 in every other cycle, including error cycles.
- Pslverr = Pready && error. An erroring write leaves all banks unchanged.
- Each bank is fully independent: the same word index in different banks holds different data.

Decomposition:
- Shared package apb_pkg: apb_state_e enum (IDLE, SETUP, ACCESS) and localparam WORD_BITS = $clog2(DEPTH), as a helper function of DEPTH.
- One sub-module is natural: apb_reg_bank. It holds a single DEPTH x DATA_WIDTH bank with synchronous write, combinational read and synchronous clear.
- The top level instantiates apb_reg_bank NUM_SLAVES times in a generate loop and owns the FSM, wait counter and decode.

Test Plan:
- Reset, then idle for 5 cycles -> Prdata=0, Pready=0, Pslverr=0 throughout. Read of any bank word returns 0x00000000.
- WAIT_STATES=0: write 0xDEADBEEF to Pselx=001, Paddr=0x8, then read it back -> Pready high in cycle 2 of each transfer, Prdata=0xDEADBEEF, Pslverr=0.
- Bank isolation: write 0x11 to bank0 word 3 (Paddr=0xC) and 0x22 to bank2 word 3 -> reads return 0x11 and 0x22 respectively. Bank1 word 3 reads 0.
- WAIT_STATES=3: single read -> Pready asserted in the 4th ACCESS cycle only (transfer = 5 cycles). Prdata=0 before that cycle.
- Errors, each giving Pslverr=1 with Pready and Prdata=0, and leaving the target word unchanged:
  - write with Paddr=0x2 (misaligned);
  - write with Paddr=0x40 at DEPTH=16 (out of range);
  - write with Pselx=011 (multi-select).
- Abort and reset cases, each leaving memory unchanged with Pready never asserted:
  - Pselx dropped mid-ACCESS with WAIT_STATES=2;
  - Hreset asserted during ACCESS of a write; afterwards the target word still reads 0.
